// File: rtl/reverse_pkg.sv
// Shared types and default constants for the reverse_bits arbiter slice.
package reverse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } rev_state_t;

  localparam int unsigned REV_WIDTH   = 8;
  localparam int unsigned REV_LATENCY = 1;

endpackage

// File: rtl/reverse_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int unsigned k;

  // Scan NUM_REQ positions starting at ptr; the first valid one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/reverse_bits.sv
// Bit-reversal datapath with a LAT-stage output pipeline.
module reverse_bits #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] original_bits,
  output logic [WIDTH-1:0] reversed_bits
);

  logic [WIDTH-1:0] flipped;
  logic [WIDTH-1:0] pipe [LAT];

  // Mirror the bit order.
  always_comb begin
    flipped = '0;
    for (int unsigned i = 0; i < WIDTH; i++) flipped[i] = original_bits[WIDTH-1-i];
  end

  // Delay the reversed word by LAT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= flipped;
      for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign reversed_bits = pipe[LAT-1];

endmodule

// File: rtl/reverse_arbiter.sv
// Round-robin front end sharing one reverse_bits datapath among NUM_REQ sources.
module reverse_arbiter
  import reverse_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = REV_WIDTH,
  parameter int unsigned REV_LAT = REV_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           rev_in,
  input  logic [WIDTH-1:0]           rev_out,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]           resp_data,
  input  logic                       resp_ready,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = (REV_LAT < 2) ? 1 : $clog2(REV_LAT + 1);

  rev_state_t           state, state_nxt;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        gnt_idx;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_any;
  logic [CW-1:0]        cnt;
  logic                 take;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Grant only when the datapath is free or the pending response drains this cycle.
  always_comb begin
    take       = rst_n && gnt_any && ((state == IDLE) || ((state == RESP) && resp_ready));
    req_ready  = take ? gnt : '0;
    resp_valid = (state == RESP);
    busy       = (state != IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE:   if (cnt == '0) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = take ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Launch a granted word, count down the datapath latency, then capture the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rev_in    <= '0;
      resp_id   <= '0;
      resp_data <= '0;
      cnt       <= '0;
      ptr       <= '0;
    end else if (take) begin
      rev_in  <= req_data[gnt_idx*WIDTH +: WIDTH];
      resp_id <= gnt_idx;
      cnt     <= CW'(REV_LAT);
      ptr     <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (state == ISSUE) begin
      if (cnt != '0) cnt       <= cnt - 1'b1;
      else           resp_data <= rev_out;
    end
  end

endmodule

// File: tb/tb_reverse_arbiter.sv
// Bench for reverse_arbiter driving a real reverse_bits instance.
module tb_reverse_arbiter;
  import reverse_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 1;
  localparam int unsigned IW  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     rev_in;
  logic [W-1:0]     rev_out;
  logic             resp_valid;
  logic [IW-1:0]    resp_id;
  logic [W-1:0]     resp_data;
  logic             resp_ready = 1'b1;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reverse_arbiter #(.NUM_REQ(N), .WIDTH(W), .REV_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rev_in     (rev_in),
    .rev_out    (rev_out),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  reverse_bits #(.WIDTH(W), .LAT(LAT)) u_rev (
    .clk           (clk),
    .rst_n         (rst_n),
    .original_bits (rev_in),
    .reversed_bits (rev_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev_ref(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  function automatic int pick_ref(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (6) next_cycle();
  endtask

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   exp_grant;
    logic [IW-1:0]  exp_id;
    logic [W-1:0]   exp_resp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [N*W-1:0] d;
    logic [W-1:0]   w;
    int             lat;
    int             g_cyc [$];
    int             g_idx [$];
    logic [W-1:0]   r_dat [$];
    int             r_id  [$];
    logic [W-1:0]   held_d;
    logic [IW-1:0]  held_id;
    int             seen;
    int             m_ptr, m_out, m_at, m_id, g;
    logic [W-1:0]   m_d;
    logic [N-1:0]   v, eg;
    logic           rr, exp_rv, can;

    vecs[0] = '{4'b0010, {8'h00, 8'h00, 8'hB4, 8'h00}, 4'b0010, 2'd1, 8'h2D};
    vecs[1] = '{4'b1111, {8'h08, 8'h04, 8'h02, 8'h01}, 4'b0100, 2'd2, 8'h20};
    vecs[2] = '{4'b0101, {8'h00, 8'h81, 8'h00, 8'h0F}, 4'b0001, 2'd0, 8'hF0};
    vecs[3] = '{4'b0101, {8'h00, 8'h81, 8'h00, 8'h0F}, 4'b0100, 2'd2, 8'h81};
    vecs[4] = '{4'b1000, {8'h12, 8'h00, 8'h00, 8'h00}, 4'b1000, 2'd3, 8'h48};

    // Reset: 3 cycles low, grants suppressed while in reset.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = '1;
    #1;
    check("req_ready_in_reset", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rev_in", 32'(rev_in), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    next_cycle();
    check("rst_busy_stays", 32'(busy), 32'd0);

    // Table of single transactions, including pointer skip (vectors 2,3).
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid  = vecs[i].valid;
      req_data   = vecs[i].data;
      resp_ready = 1'b1;
      #1;
      check("vec_grant", 32'(req_ready), 32'(vecs[i].exp_grant));
      next_cycle();
      req_valid = '0;
      d = vecs[i].data;
      w = d[vecs[i].exp_id*W +: W];
      check("vec_rev_in", 32'(rev_in), 32'(w));
      check("vec_busy", 32'(busy), 32'd1);
      lat = 1;
      while (!resp_valid && lat < 12) begin
        next_cycle();
        lat++;
      end
      check("vec_resp_latency", 32'(lat), 32'(LAT + 2));
      check("vec_resp_data", 32'(resp_data), 32'(vecs[i].exp_resp));
      check("vec_resp_id", 32'(resp_id), 32'(vecs[i].exp_id));
      next_cycle();
      check("vec_done_valid", 32'(resp_valid), 32'd0);
      check("vec_done_busy", 32'(busy), 32'd0);
    end

    // Continuous round-robin with all four sources valid; pointer is 0 here.
    @(negedge clk);
    req_valid  = 4'b1111;
    req_data   = {8'h08, 8'h04, 8'h02, 8'h01};
    resp_ready = 1'b1;
    #1;
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < N; k++) if (req_ready[k]) begin g_cyc.push_back(c); g_idx.push_back(k); end
      if (resp_valid) begin r_dat.push_back(resp_data); r_id.push_back(int'(resp_id)); end
      next_cycle();
    end
    drain();
    check("rr_grant_count", 32'(g_idx.size() >= 5), 32'd1);
    check("rr_resp_count", 32'(r_dat.size() >= 4), 32'd1);
    for (int k = 0; k < 5 && k < g_idx.size(); k++) begin
      check("rr_grant_idx", 32'(g_idx[k]), 32'(k % N));
      if (k > 0) check("rr_grant_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'(LAT + 2));
    end
    for (int k = 0; k < 4 && k < r_dat.size(); k++) begin
      check("rr_resp_data", 32'(r_dat[k]), 32'(8'h80 >> k));
      check("rr_resp_id", 32'(r_id[k]), 32'(k));
    end

    // Backpressure: grants went 0,1,2,3,0,1 so the pointer is 2.
    @(negedge clk);
    req_valid  = 4'b1111;
    resp_ready = 1'b0;
    #1;
    check("bp_grant", 32'(req_ready), 32'b0100);
    lat = 0;
    while (!resp_valid && lat < 12) begin
      next_cycle();
      lat++;
    end
    check("bp_resp_valid", 32'(resp_valid), 32'd1);
    held_d  = resp_data;
    held_id = resp_id;
    check("bp_resp_data", 32'(held_d), 32'h20);
    check("bp_resp_id", 32'(held_id), 32'd2);
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_data", 32'(resp_data), 32'(held_d));
      check("bp_hold_id", 32'(resp_id), 32'(held_id));
      check("bp_no_grant", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    check("bp_release_grant", 32'(req_ready), 32'b1000);
    next_cycle();
    check("bp_after_valid", 32'(resp_valid), 32'd0);
    check("bp_after_busy", 32'(busy), 32'd1);
    drain();

    // Mid-flight reset; pointer is 0 after the grant to 3.
    @(negedge clk);
    req_valid  = 4'b0010;
    req_data   = {8'h00, 8'h00, 8'hB4, 8'h00};
    resp_ready = 1'b1;
    #1;
    check("mf_grant", 32'(req_ready), 32'b0010);
    next_cycle();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("mf_rev_in", 32'(rev_in), 32'd0);
    check("mf_busy", 32'(busy), 32'd0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      if (resp_valid) seen++;
    end
    check("mf_no_resp", 32'(seen), 32'd0);
    check("mf_rev_in_after", 32'(rev_in), 32'd0);
    req_valid = 4'b1111;
    #1;
    check("mf_ptr_zero", 32'(req_ready), 32'b0001);
    drain();

    // Randomized traffic against a transaction-level model.
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    m_ptr = 0; m_out = 0; m_at = 0; m_id = 0; m_d = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      v  = 4'($urandom_range(0, 15)) & (($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15)));
      rr = ($urandom_range(0, 3) != 0);
      req_valid  = v;
      req_data   = {$urandom};
      resp_ready = rr;
      #1;
      exp_rv = (m_out != 0) && (n >= m_at);
      check("rnd_resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv) begin
        check("rnd_resp_data", 32'(resp_data), 32'(m_d));
        check("rnd_resp_id", 32'(resp_id), 32'(m_id));
      end
      can = (m_out == 0) || (exp_rv && rr);
      g   = can ? pick_ref(v, m_ptr) : -1;
      eg  = (g >= 0) ? (N'(1) << g) : '0;
      check("rnd_grant", 32'(req_ready), 32'(eg));
      if (exp_rv && rr) m_out = 0;
      if (g >= 0) begin
        d     = req_data;
        m_out = 1;
        m_at  = n + LAT + 2;
        m_d   = rev_ref(d[g*W +: W]);
        m_id  = g;
        m_ptr = (g + 1) % N;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reverse_arbiter.md
# reverse_arbiter

Round-robin controller that shares a single `reverse_bits` datapath among `NUM_REQ` requesters. It accepts one word at a time over a valid/ready handshake and drives it into the `reverse_bits` input. After the datapath latency it captures the reversed word and returns it with the requester ID over a valid/ready response channel. It sits between the word sources (e.g. `bit_input` instances) and the one `reverse_bits` instance, on the common `clk`.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 8: word width.
- `REV_LAT`, 1: `reverse_bits` latency in cycles, ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_data`  in  NUM_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NUM_REQ  one-hot grant/accept, combinational.
- `rev_in`  out  WIDTH  to `reverse_bits.original_bits`, registered.
- `rev_out`  in  WIDTH  from `reverse_bits.reversed_bits`.
- `resp_valid`  out  1  response available.
- `resp_id`  out  $clog2(NUM_REQ)  index of the requester that owns `resp_data`.
- `resp_data`  out  WIDTH  reversed word.
- `resp_ready`  in  1  response consumer ready.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE:** if any `req_valid` is set, the round-robin picker selects g and asserts `req_ready[g]`. On the clock edge:
  - `rev_in <= req_data[g]`, `resp_id <= g`, `cnt <= REV_LAT`.
  - Pointer becomes (g+1) mod NUM_REQ.
  - FSM moves to ISSUE.
- **ISSUE:** while `cnt != 0`, decrement `cnt`. When `cnt == 0`, `resp_data <= rev_out` on that edge and the FSM moves to RESP.
- **RESP:** `resp_valid = 1`; `resp_data` and `resp_id` are held stable.
  - If `resp_ready` is high, the response completes this cycle.
  - In that same cycle the picker may grant a new request. If it does, it follows the IDLE grant actions and the FSM goes to ISSUE. Otherwise the FSM goes to IDLE.
- **Round-robin:** the search starts at the pointer and wraps. Requesters that are not valid are skipped. Pointer reset value is 0.
- `req_ready` is 0 in ISSUE, 0 in RESP with `resp_ready` = 0, and 0 whenever `rst_n` = 0.
- `rev_in` holds its last value when idle; it changes only on a grant.
- Reset values: state IDLE, `rev_in` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_data` = 0, `cnt` = 0, pointer = 0, `busy` = 0.
- Asserting reset mid-operation discards any in-flight word. No response is issued for it and the requester must re-request.
- A requester that drops `req_valid` before it is granted loses nothing: grants are evaluated only on the current cycle.

## Timing
- Grant at cycle T (`req_ready[g]` high; handshake completes at the end of T).
- `rev_in` presents the word from T+1.
- `resp_data` is captured at the end of cycle T+REV_LAT+1.
- `resp_valid` rises at T+REV_LAT+2, i.e. T+3 for the default.
- Best-case throughput: one word per REV_LAT+2 cycles (3 by default), achieved with `resp_ready` held high and requests pending.
- No combinational path from `rev_out` to any output. `req_ready` depends combinationally on `req_valid`, state and `resp_ready` only.

## Structure
- Package `reverse_pkg` holds:
  - the state enum `rev_state_t` {IDLE, ISSUE, RESP};
  - default constants `REV_WIDTH` = 8 and `REV_LATENCY` = 1.
- Sub-module `rr_pick` (combinational):
  - inputs: request vector, pointer;
  - outputs: one-hot grant, grant index, any-grant flag.
- The FSM, counter and data registers stay in `reverse_arbiter`.
- The bench instantiates `reverse_arbiter` together with a real `reverse_bits`.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles, then release with `req_valid` = 0 → all outputs 0; `busy` stays 0.
- **Single request:** `req_data[1]` = 8'hB4, `req_valid` = 4'b0010 at T, `resp_ready` = 1 → `req_ready` = 4'b0010 at T, `rev_in` = 8'hB4 at T+1, `resp_valid` at T+3 with `resp_data` = 8'h2D and `resp_id` = 1.
- **Round-robin:** all four requesters valid continuously with data 8'h01/8'h02/8'h04/8'h08, `resp_ready` = 1 → grants go 0,1,2,3,0, spaced 3 cycles apart; responses are 8'h80/8'h40/8'h20/8'h10 with matching IDs.
- **Backpressure:** `resp_ready` = 0 for 5 cycles during RESP → `resp_valid`/`resp_data`/`resp_id` stay stable and `req_ready` stays 0. On release, the response completes and the next grant occurs in the same cycle.
- **Pointer skip:** last grant was 2 (pointer = 3); `req_valid` = 4'b0101 → next grant is 0, then 2.
- **Mid-flight reset:** assert `rst_n` = 0 in the cycle after a grant (ISSUE) → `resp_valid` never rises for that word; after release, FSM is IDLE, pointer = 0 and `rev_in` = 0.
